// File: rtl/fetch_pkg.sv
// Shared defaults and types for the instruction-fetch front end.
package fetch_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  // One queued fetch result at the default address width.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [31:0]             inst;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Registered FIFO with flush; head entry is read combinationally from storage.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[head_q];

  // Flush cancels any same-cycle push/pop; pointers wrap at the power-of-2 depth.
  always_comb begin
    do_pop  = pop && !empty && !flush;
    do_push = push && (!full || do_pop) && !flush;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + PW'(1);
      if (do_pop)  head_d = head_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: contents are only visible when count is nonzero.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[tail_q] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the fetch PC, keeps several imem requests in flight,
// queues returned instructions toward decode and squashes on redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN            = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(RESET_PC_DEFAULT),
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [31:0]                imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [31:0]                dec_inst,
  output logic [XLEN-1:0]            dec_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = $clog2(MAX_OUTSTANDING+1);

  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]    rsp_pc_q, rsp_pc_d;
  logic [OW-1:0]      outstanding_q, outstanding_d;
  logic [OW-1:0]      discard_q, discard_d;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full, fifo_empty;
  logic [XLEN+31:0]   fifo_wdata, fifo_rdata;
  logic [XLEN-1:0]    redirect_aligned;
  logic               req_fire, rsp_ok, drop, push, pop;
  logic [1:0]         unused_redirect_lsb;

  assign redirect_aligned    = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = redirect_pc[1:0];

  // Request gating: queue slots are reserved for every in-flight request, so a
  // response always has somewhere to land.
  always_comb begin
    imem_req_valid = !reset && !redirect_valid
                     && ((int'(fifo_count) + int'(outstanding_q)) < DEPTH)
                     && (int'(outstanding_q) < MAX_OUTSTANDING);
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_ok         = imem_rsp_valid && (outstanding_q != '0);
    drop           = (discard_q != '0);
    push           = rsp_ok && !drop && !redirect_valid;
    pop            = !fifo_empty && dec_ready && !redirect_valid;
  end

  // Next PC and counter state; a redirect overrides everything else this cycle.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (redirect_valid) begin
      fetch_pc_d    = redirect_aligned;
      rsp_pc_d      = redirect_aligned;
      outstanding_d = outstanding_q - OW'(rsp_ok);
      discard_d     = outstanding_q - OW'(rsp_ok);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      outstanding_d = outstanding_q + OW'(req_fire) - OW'(rsp_ok);
      if (rsp_ok) begin
        if (drop) discard_d = discard_q - OW'(1);
        else      rsp_pc_d  = rsp_pc_q + XLEN'(4);
      end
    end
  end

  // PC and in-flight bookkeeping registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  assign fifo_wdata = {rsp_pc_q, imem_rsp_data};

  sync_fifo #(
    .WIDTH(XLEN + 32),
    .DEPTH(DEPTH)
  ) u_queue (
    .clock(clock),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .wdata(fifo_wdata),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign dec_valid = !fifo_empty;
  assign dec_pc    = fifo_rdata[XLEN+31:32];
  assign dec_inst  = fifo_rdata[31:0];
  assign occupancy = fifo_count;

  a_rsp_has_outstanding: assert property (@(posedge clock) disable iff (reset)
    imem_rsp_valid |-> (outstanding_q != '0));

  a_no_push_when_full: assert property (@(posedge clock) disable iff (reset)
    !(push && fifo_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle-latency imem model (inst = address).
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] B = 32'h0100_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_inst, dec_pc;
  logic [2:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] pending[$];

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock         (clock),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_inst      (dec_inst),
    .dec_pc        (dec_pc),
    .occupancy     (occupancy)
  );

  typedef struct {
    logic        dr;
    logic        dv;
    logic [31:0] pc;
    int          occ;
    logic        rv;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Set inputs for the coming cycle; the imem returns the oldest accepted address when enabled.
  task automatic drive(input logic dr, input logic rr, input logic rv,
                       input logic [31:0] rpc, input logic rsp_en);
    dec_ready      = dr;
    imem_req_ready = rr;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (rsp_en && pending.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pending.pop_front();
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = INST_NOP;
    end
    #1;
  endtask

  task automatic tick();
    logic        hs;
    logic [31:0] a;
    hs = imem_req_valid && imem_req_ready;
    a  = imem_req_addr;
    @(posedge clock);
    #1;
    if (hs) pending.push_back(a);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    pending.delete();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    // Stream then backpressure: dr, dv, dec_pc, occupancy, req_valid, req_addr
    vecs[0]  = '{1'b1, 1'b0, 32'h0,    0, 1'b1, B + 32'h00};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,    0, 1'b1, B + 32'h04};
    vecs[2]  = '{1'b1, 1'b1, B + 32'h00, 1, 1'b1, B + 32'h08};
    vecs[3]  = '{1'b1, 1'b1, B + 32'h04, 1, 1'b1, B + 32'h0C};
    vecs[4]  = '{1'b1, 1'b1, B + 32'h08, 1, 1'b1, B + 32'h10};
    vecs[5]  = '{1'b0, 1'b1, B + 32'h0C, 1, 1'b1, B + 32'h14};
    vecs[6]  = '{1'b0, 1'b1, B + 32'h0C, 2, 1'b1, B + 32'h18};
    vecs[7]  = '{1'b0, 1'b1, B + 32'h0C, 3, 1'b0, B + 32'h1C};
    vecs[8]  = '{1'b0, 1'b1, B + 32'h0C, 4, 1'b0, B + 32'h1C};
    vecs[9]  = '{1'b1, 1'b1, B + 32'h0C, 4, 1'b0, B + 32'h1C};
    vecs[10] = '{1'b1, 1'b1, B + 32'h10, 3, 1'b1, B + 32'h1C};
    vecs[11] = '{1'b1, 1'b1, B + 32'h14, 2, 1'b1, B + 32'h20};
    vecs[12] = '{1'b1, 1'b1, B + 32'h18, 2, 1'b1, B + 32'h24};
    vecs[13] = '{1'b1, 1'b1, B + 32'h1C, 2, 1'b1, B + 32'h28};
    vecs[14] = '{1'b1, 1'b1, B + 32'h20, 2, 1'b1, B + 32'h2C};

    // Reset state while reset is held
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    pending.delete();
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].dr, 1'b1, 1'b0, 32'h0, 1'b1);
      chk($sformatf("v%0d_dec_valid", i), 32'(dec_valid), 32'(vecs[i].dv));
      if (vecs[i].dv) begin
        chk($sformatf("v%0d_dec_pc", i), dec_pc, vecs[i].pc);
        chk($sformatf("v%0d_dec_inst", i), dec_inst, vecs[i].pc);
      end
      chk($sformatf("v%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].occ));
      chk($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].rv));
      chk($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].addr);
      tick();
    end

    // Redirect with two requests in flight: both responses squashed
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1); tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b1, B + 32'h100, 1'b0);
    chk("rd2_req_valid_in_redirect", 32'(imem_req_valid), 32'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("rd2_req_addr", imem_req_addr, B + 32'h100);
    chk("rd2_req_valid_full_inflight", 32'(imem_req_valid), 32'd0);
    chk("rd2_dec_valid_c3", 32'(dec_valid), 32'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("rd2_req_valid_c4", 32'(imem_req_valid), 32'd1);
    chk("rd2_dec_valid_c4", 32'(dec_valid), 32'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("rd2_dec_valid_c5", 32'(dec_valid), 32'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("rd2_dec_valid_c6", 32'(dec_valid), 32'd1);
    chk("rd2_dec_pc", dec_pc, B + 32'h100);
    chk("rd2_dec_inst", dec_inst, B + 32'h100);
    tick();

    // Redirect, response and pop all in one cycle
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1); tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1); tick();
    drive(1'b1, 1'b1, 1'b1, B + 32'h40, 1'b1);
    chk("sim_pre_dec_valid", 32'(dec_valid), 32'd1);
    chk("sim_pre_rsp_valid", 32'(imem_rsp_valid), 32'd1);
    chk("sim_req_blocked", 32'(imem_req_valid), 32'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("sim_occupancy", 32'(occupancy), 32'd0);
    chk("sim_dec_valid", 32'(dec_valid), 32'd0);
    chk("sim_req_valid", 32'(imem_req_valid), 32'd1);
    chk("sim_req_addr", imem_req_addr, B + 32'h40);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("sim_dec_valid_c4", 32'(dec_valid), 32'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("sim_dec_pc", dec_pc, B + 32'h40);
    tick();

    // Misaligned redirect followed by a 3-cycle request stall
    do_reset();
    drive(1'b1, 1'b0, 1'b1, B + 32'h102, 1'b1); tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk($sformatf("stall%0d_req_valid", k), 32'(imem_req_valid), 32'd1);
      chk($sformatf("stall%0d_req_addr", k), imem_req_addr, B + 32'h100);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall_release_addr", imem_req_addr, B + 32'h100);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall_next_addr", imem_req_addr, B + 32'h104);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall_dec_pc", dec_pc, B + 32'h100);
    tick();

    // Reset mid-stream with the credit budget used up (2 queued + 2 in flight)
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1); tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1); tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1); tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("mid_pre_occupancy", 32'(occupancy), 32'd2);
    chk("mid_pre_req_valid", 32'(imem_req_valid), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_req_valid_in_reset", 32'(imem_req_valid), 32'd0);
    tick();
    pending.delete();
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("mid_occupancy", 32'(occupancy), 32'd0);
    chk("mid_dec_valid", 32'(dec_valid), 32'd0);
    chk("mid_req_valid", 32'(imem_req_valid), 32'd1);
    chk("mid_req_addr", imem_req_addr, B);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
